// File: rtl/fir_optimized_sdiv_32s_10s_seq.sv
// Sequential signed divider (restoring, one quotient bit per enabled cycle).
// Truncate-toward-zero quotient; remainder takes the dividend's sign.
module fir_optimized_sdiv_32s_10s_seq #(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero,
  output logic                  ovf
);
  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int CW = $clog2(W0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W0:0] MAX_NEG_MAG = {2'b01, {(W0-1){1'b0}}};

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [W0-1:0]         r_dvd;
  logic [W1:0]           r_dsr;
  logic [W1:0]           r_prem;
  logic                  r_qneg;
  logic                  r_rneg;
  logic                  r_dz_lat;
  logic                  r_ovf_lat;
  logic [dout_WIDTH-1:0] r_quot;
  logic [W1-1:0]         r_rem;
  logic                  r_div_zero;
  logic                  r_ovf;

  logic          w_neg0;
  logic          w_neg1;
  logic [W0:0]   w_sx0;
  logic [W0:0]   w_abs0;
  logic [W1:0]   w_sx1;
  logic [W1:0]   w_abs1;
  logic          w_dz;
  logic          w_ovf;
  logic [W1+1:0] w_shift;
  logic [W1+1:0] w_trial;
  logic          w_take;
  logic [W0-1:0] w_qfix;
  logic [W1-1:0] w_rfix;
  logic          w_unused;

  // Magnitudes are one bit wider than the operands so the most-negative value survives.
  assign w_neg0 = din0[W0-1];
  assign w_neg1 = din1[W1-1];
  assign w_sx0  = {din0[W0-1], din0};
  assign w_sx1  = {din1[W1-1], din1};
  assign w_abs0 = w_neg0 ? -w_sx0 : w_sx0;
  assign w_abs1 = w_neg1 ? -w_sx1 : w_sx1;
  assign w_dz   = (din1 == '0);
  assign w_ovf  = w_neg0 && (w_abs0 == MAX_NEG_MAG) && (din1 == '1);

  // Dividend register doubles as the quotient shift register.
  assign w_shift = {r_prem, r_dvd[W0-1]};
  assign w_take  = (w_shift >= {1'b0, r_dsr});
  assign w_trial = w_shift - {1'b0, r_dsr};

  assign w_qfix = r_qneg ? -r_dvd : r_dvd;
  assign w_rfix = r_rneg ? -r_prem[W1-1:0] : r_prem[W1-1:0];

  assign w_unused = ^{w_shift[W1+1], w_trial[W1+1], r_prem[W1]};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign div_zero  = r_div_zero;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_prem     <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_dz_lat   <= 1'b0;
      r_ovf_lat  <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd      <= w_abs0[W0-1:0];
            r_dsr      <= w_abs1;
            r_prem     <= '0;
            r_cnt      <= CW'(W0-1);
            r_qneg     <= w_neg0 ^ w_neg1;
            r_rneg     <= w_neg0;
            r_dz_lat   <= w_dz;
            r_ovf_lat  <= w_ovf;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_state    <= w_dz ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_prem <= w_take ? w_trial[W1:0] : w_shift[W1:0];
          r_dvd  <= {r_dvd[W0-2:0], w_take};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIX: begin
          r_quot     <= r_dz_lat ? '1 : w_qfix;
          r_rem      <= r_dz_lat ? '0 : w_rfix;
          r_div_zero <= r_dz_lat;
          r_ovf      <= r_ovf_lat;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_optimized_sdiv_32s_10s_seq.sv
// Scoreboard bench for the sequential signed divider: driver pushes C-model
// results on accept, monitor pops and compares whenever out_valid appears.
module tb_fir_optimized_sdiv_32s_10s_seq;
  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din0;
  logic [9:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quot;
  logic [9:0]  rem;
  logic        div_zero;
  logic        ovf;

  typedef struct {
    logic [31:0] q;
    logic [9:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic rand_mode = 1'b0;

  fir_optimized_sdiv_32s_10s_seq #(
    .din0_WIDTH(32),
    .din1_WIDTH(10),
    .dout_WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rand_mode) begin
      ce        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // C semantics: truncating division, remainder sign follows dividend.
  function automatic exp_t model(input logic [31:0] a, input logic [9:0] b);
    exp_t   e;
    longint sa;
    longint sd;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    e.lat = -1;
    e.acc = 0;
    if (sd == 0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = 10'd0;
      e.dz = 1'b1;
      e.ov = 1'b0;
    end else begin
      q    = sa / sd;
      r    = sa % sd;
      e.q  = q[31:0];
      e.r  = r[9:0];
      e.dz = 1'b0;
      e.ov = (q > 64'sd2147483647);
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [9:0] b, input int lat);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk); #1;
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    while (!(in_ready && ce && reset) && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 3000) begin
      chk("accept_timeout", 64'd1, 64'd0);
    end else begin
      e     = model(a, b);
      e.lat = lat;
      e.acc = cyc;
      last_acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    din0     = $urandom;
    din1     = 10'($urandom);
  endtask

  task automatic wait_valid();
    int guard;
    guard = 0;
    while (!out_valid && guard < 3000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 3000) chk("valid_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 5000) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  // Monitor: compare on first appearance of a result, then hold it stable.
  initial begin
    logic        seen;
    exp_t        e;
    logic [31:0] hq;
    logic [9:0]  hr;
    logic        hdz;
    logic        hov;
    seen = 1'b0;
    hq = '0; hr = '0; hdz = 1'b0; hov = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 1'b0;
      end else if (out_valid) begin
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (!seen) begin
          seen = 1'b1;
          if (sb.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("quot", 64'(quot), 64'(e.q));
            chk("rem", 64'(rem), 64'(e.r));
            chk("div_zero", 64'(div_zero), 64'(e.dz));
            chk("ovf", 64'(ovf), 64'(e.ov));
            if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          hq = quot; hr = rem; hdz = div_zero; hov = ovf;
        end else begin
          chk("hold_quot", 64'(quot), 64'(hq));
          chk("hold_rem", 64'(rem), 64'(hr));
          chk("hold_flags", 64'({div_zero, ovf}), 64'({hdz, hov}));
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    int a1;
    logic [31:0] a;
    logic [9:0]  b;
    reset     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b1;
    din0      = 32'd55;
    din1      = 10'd5;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_quot", 64'(quot), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_flags", 64'({div_zero, ovf}), 64'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // 100/7 with garbage in_valid while busy: must not be recaptured
    issue(32'd100, 10'd7, 34);
    in_valid = 1'b1;
    repeat (20) @(negedge clk);
    #1 in_valid = 1'b0;
    issue(32'd7, 10'd100, 34);
    issue(32'd0, 10'd7, 34);
    issue(32'(-100), 10'd7, 34);
    issue(32'd100, 10'(-7), 34);
    issue(32'(-100), 10'(-7), 34);
    issue(32'h7FFF_FFFF, 10'd511, 34);
    issue(32'h8000_0000, 10'h200, 34);
    issue(32'd1234, 10'd0, 2);
    issue(32'h8000_0000, 10'h3FF, 34);

    // back-to-back spacing
    issue(32'd99999, 10'd13, 34);
    a1 = last_acc;
    issue(32'(-99999), 10'd13, 34);
    chk("accept_spacing", 64'(last_acc - a1), 64'd35);

    // backpressure
    wait_drain();
    out_ready = 1'b0;
    issue(32'(-123456), 10'd77, 34);
    wait_valid();
    repeat (20) @(negedge clk);
    #1;
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;

    // ce stall of 5 cycles mid-CALC
    issue(32'd100, 10'd7, 39);
    repeat (8) @(negedge clk);
    #1 ce = 1'b0;
    repeat (5) @(negedge clk);
    #1 ce = 1'b1;
    wait_drain();

    // random regression with random ce / out_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h8000_0000;
        1:       a = 32'h7FFF_FFFF;
        2:       a = $urandom_range(0, 200);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 11))
        0:       b = 10'd0;
        1:       b = 10'h3FF;
        2:       b = 10'h200;
        3:       b = 10'h1FF;
        4:       b = 10'd1;
        default: b = 10'($urandom);
      endcase
      issue(a, b, -1);
      if (i == 500) begin
        repeat (10) @(negedge clk);
        #1 reset = 1'b0;
        sb.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_quot", 64'(quot), 64'd0);
        chk("midrst_flags", 64'({div_zero, ovf}), 64'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_no_stale", 64'(out_valid), 64'd0);
      end
    end
    rand_mode = 1'b0;
    @(negedge clk); #1;
    ce        = 1'b1;
    out_ready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
